compute_sched_ctrl: RTL

COMPUTE_SCHED_CTRL -- requirements
Module: compute_sched_ctrl

---
 rtl/compute_pkg.sv | 36 +++
 rtl/sched_cycle_cnt.sv | 37 +++
 rtl/compute_sched_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/compute_pkg.sv
// Shared definitions for the compute scheduler: FSM encoding, engine indices,
// default timing parameters and the engine-ordering helper.
package compute_pkg;

  localparam int LOAD_CYCLES_DEF = 3;
  localparam int TIMEOUT_DEF     = 64;
  localparam int CNT_W           = 8;

  localparam logic [1:0] ENG_PE  = 2'd0;
  localparam logic [1:0] ENG_SA3 = 2'd1;
  localparam logic [1:0] ENG_SA2 = 2'd2;

  // Engines still to run once the named engine has finished.
  localparam logic [2:0] AFTER_PE  = 3'b110;
  localparam logic [2:0] AFTER_SA3 = 3'b100;
  localparam logic [2:0] AFTER_SA2 = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_PE_RUN   = 3'd2,
    ST_SA3_RUN  = 3'd3,
    ST_SA2_RUN  = 3'd4,
    ST_WAIT_CAP = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // First remaining enabled engine in PE, SA3, SA2 order; WAIT_CAP when none left.
  function automatic state_e next_run_state(input logic [2:0] rem);
    if (rem[ENG_PE])  return ST_PE_RUN;
    if (rem[ENG_SA3]) return ST_SA3_RUN;
    if (rem[ENG_SA2]) return ST_SA2_RUN;
    return ST_WAIT_CAP;
  endfunction

endpackage

// File: rtl/sched_cycle_cnt.sv
// Window counter shared by LOAD and the engine RUN states: cleared on state
// entry, counts while enabled, flags the last cycle of a limit_i-cycle window.
module sched_cycle_cnt
  import compute_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == (limit_i - W'(1)));

endmodule

// File: rtl/compute_sched_ctrl.sv
// Job sequencer: operand load, then each enabled engine in turn (with a
// per-engine timeout), then wait for memory capture and pulse done.
module compute_sched_ctrl
  import compute_pkg::*;
#(
  parameter int LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [2:0] cfg_en_i,
  input  logic       pe_done_i,
  input  logic       sa3_done_i,
  input  logic       sa2_done_i,
  input  logic       done_capture_i,
  output logic       run_valid_o,
  output logic       PE_valid_o,
  output logic       SA_3x3_valid_o,
  output logic       SA_2x2_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  state_e     state_q, state_d;
  logic [2:0] en_q, en_d;
  logic       err_q, err_d;

  logic run_valid_q, pe_valid_q, sa3_valid_q, sa2_valid_q, busy_q, done_q;

  logic             cnt_clear, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_limit;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          en_d    = cfg_en_i;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cnt_tc) begin
          state_d = (en_q == 3'b000) ? ST_DONE : next_run_state(en_q);
        end
      end
      ST_PE_RUN: begin
        if (pe_done_i || cnt_tc) begin
          state_d = next_run_state(en_q & AFTER_PE);
          if (!pe_done_i) err_d = 1'b1;
        end
      end
      ST_SA3_RUN: begin
        if (sa3_done_i || cnt_tc) begin
          state_d = next_run_state(en_q & AFTER_SA3);
          if (!sa3_done_i) err_d = 1'b1;
        end
      end
      ST_SA2_RUN: begin
        if (sa2_done_i || cnt_tc) begin
          state_d = next_run_state(en_q & AFTER_SA2);
          if (!sa2_done_i) err_d = 1'b1;
        end
      end
      ST_WAIT_CAP: begin
        if (done_capture_i) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything decided above, including a timeout in the same cycle.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      err_d   = err_q;
    end
  end

  assign cnt_en    = (state_q == ST_LOAD) || (state_q == ST_PE_RUN) ||
                     (state_q == ST_SA3_RUN) || (state_q == ST_SA2_RUN);
  assign cnt_clear = (state_d != state_q);
  assign cnt_limit = (state_q == ST_LOAD) ? CNT_W'(LOAD_CYCLES) : CNT_W'(TIMEOUT);

  sched_cycle_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .limit_i (cnt_limit),
    .tc_o    (cnt_tc)
  );

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      en_q        <= 3'b000;
      err_q       <= 1'b0;
      run_valid_q <= 1'b0;
      pe_valid_q  <= 1'b0;
      sa3_valid_q <= 1'b0;
      sa2_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      err_q       <= err_d;
      run_valid_q <= (state_d == ST_LOAD);
      pe_valid_q  <= (state_d == ST_PE_RUN);
      sa3_valid_q <= (state_d == ST_SA3_RUN);
      sa2_valid_q <= (state_d == ST_SA2_RUN);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign run_valid_o    = run_valid_q;
  assign PE_valid_o     = pe_valid_q;
  assign SA_3x3_valid_o = sa3_valid_q;
  assign SA_2x2_valid_o = sa2_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign state_o        = state_q;

endmodule
